// File: rtl/usb3_slfifo_rd.sv
// usb3_slfifo_rd: reads fixed-length bursts from an FX3 slave FIFO.
// Sequences SLCS_N/SLOE_N/SLRD_N, realigns the returning data with a
// RD_LATENCY-deep valid/last pipeline and counts completed full packets.
// RD_LATENCY must be at least 1.
module usb3_slfifo_rd #(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [1:0]  FIFO_ADDR  = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        USB3_FLAGA,
  input  logic [31:0] USB3_DQ,
  input  logic        ds_ready,
  output logic        USB3_SLCS_N,
  output logic        USB3_SLOE_N,
  output logic        USB3_SLRD_N,
  output logic [1:0]  USB3_A,
  output logic [3:0]  usb_rd_state,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic        short_pkt,
  output logic [15:0] pkt_count
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] ADDR  = 4'd1;
  localparam logic [3:0] WAIT  = 4'd2;
  localparam logic [3:0] READ  = 4'd6;
  localparam logic [3:0] DRAIN = 4'd7;
  localparam logic [3:0] DONE  = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [15:0]           drain_cnt_q, drain_cnt_d;
  logic                  short_q, short_d;
  logic                  rd_now, rd_last;
  logic                  done_entry;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic [31:0]           data_out_q;
  logic                  short_pkt_q;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic                  slcs_n_q, slcs_n_d;
  logic                  sloe_n_q, sloe_n_d;
  logic                  slrd_n_q, slrd_n_d;

  // Next-state logic: burst sequencing, word and drain counting.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    drain_cnt_d = drain_cnt_q;
    short_d     = short_q;
    rd_now      = 1'b0;
    rd_last     = 1'b0;
    case (state_q)
      IDLE: begin
        word_cnt_d  = 16'd0;
        drain_cnt_d = 16'd0;
        short_d     = 1'b0;
        if (USB3_FLAGA && ds_ready) begin
          state_d = ADDR;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: state_d = READ;
      READ: begin
        rd_now     = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
        // A flag drop on the final word still completes a full burst.
        if (word_cnt_q == 16'(BURST_LEN - 1)) begin
          rd_last = 1'b1;
          state_d = DRAIN;
        end else if (!USB3_FLAGA) begin
          rd_last = 1'b1;
          short_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 16'd1;
        if (drain_cnt_q == 16'(RD_LATENCY - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!USB3_FLAGA) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode from the next state so the pins come straight from flops.
  always_comb begin
    slcs_n_d = 1'b1;
    sloe_n_d = 1'b1;
    slrd_n_d = 1'b1;
    case (state_d)
      ADDR: slcs_n_d = 1'b0;
      WAIT: begin
        slcs_n_d = 1'b0;
        sloe_n_d = 1'b0;
      end
      READ: begin
        slcs_n_d = 1'b0;
        sloe_n_d = 1'b0;
        slrd_n_d = 1'b0;
      end
      DRAIN: begin
        slcs_n_d = 1'b0;
        sloe_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Latency pipeline and packet bookkeeping next values.
  always_comb begin
    vld_pipe_d  = (vld_pipe_q << 1) | RD_LATENCY'(rd_now);
    last_pipe_d = (last_pipe_q << 1) | RD_LATENCY'(rd_last);
    done_entry  = (state_q == DRAIN) && (state_d == DONE);
    pkt_count_d = pkt_count_q;
    if (done_entry && !short_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  // State, counters, pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= 16'd0;
      drain_cnt_q <= 16'd0;
      short_q     <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      data_out_q  <= 32'd0;
      short_pkt_q <= 1'b0;
      pkt_count_q <= 16'd0;
      slcs_n_q    <= 1'b1;
      sloe_n_q    <= 1'b1;
      slrd_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      short_q     <= short_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      short_pkt_q <= done_entry & short_q;
      pkt_count_q <= pkt_count_d;
      slcs_n_q    <= slcs_n_d;
      sloe_n_q    <= sloe_n_d;
      slrd_n_q    <= slrd_n_d;
      // Capture on the same edge that raises data_valid for this word.
      if (vld_pipe_d[RD_LATENCY-1]) begin
        data_out_q <= USB3_DQ;
      end
    end
  end

  assign USB3_SLCS_N  = slcs_n_q;
  assign USB3_SLOE_N  = sloe_n_q;
  assign USB3_SLRD_N  = slrd_n_q;
  assign USB3_A       = FIFO_ADDR;
  assign usb_rd_state = state_q;
  assign data_out     = data_out_q;
  assign data_valid   = vld_pipe_q[RD_LATENCY-1];
  assign data_last    = last_pipe_q[RD_LATENCY-1];
  assign short_pkt    = short_pkt_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_usb3_slfifo_rd.sv
// tb_usb3_slfifo_rd: randomized bench with an FX3 slave-FIFO model and a
// cycle-accurate word scoreboard, plus a second instance at RD_LATENCY=3.
module tb_usb3_slfifo_rd;

  localparam int unsigned BL  = 256;
  localparam int unsigned LAT = 2;
  localparam logic [1:0]  FA  = 2'b01;

  logic        clk;
  logic        rst_n;
  logic        USB3_FLAGA;
  logic [31:0] USB3_DQ;
  logic        ds_ready;
  logic        USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N;
  logic [1:0]  USB3_A;
  logic [3:0]  usb_rd_state;
  logic [31:0] data_out;
  logic        data_valid, data_last, short_pkt;
  logic [15:0] pkt_count;

  // Second instance for the latency sweep.
  logic        f3, ds3;
  logic [31:0] dq3;
  logic        cs3, oe3, rd3, valid3, last3, short3;
  logic [1:0]  a3;
  logic [3:0]  state3;
  logic [31:0] out3;
  logic [15:0] cnt3;

  usb3_slfifo_rd #(.BURST_LEN(BL), .RD_LATENCY(LAT), .FIFO_ADDR(FA)) dut (
    .clk(clk), .rst_n(rst_n), .USB3_FLAGA(USB3_FLAGA), .USB3_DQ(USB3_DQ),
    .ds_ready(ds_ready), .USB3_SLCS_N(USB3_SLCS_N), .USB3_SLOE_N(USB3_SLOE_N),
    .USB3_SLRD_N(USB3_SLRD_N), .USB3_A(USB3_A), .usb_rd_state(usb_rd_state),
    .data_out(data_out), .data_valid(data_valid), .data_last(data_last),
    .short_pkt(short_pkt), .pkt_count(pkt_count)
  );

  usb3_slfifo_rd #(.BURST_LEN(8), .RD_LATENCY(3), .FIFO_ADDR(2'b00)) dut3 (
    .clk(clk), .rst_n(rst_n), .USB3_FLAGA(f3), .USB3_DQ(dq3), .ds_ready(ds3),
    .USB3_SLCS_N(cs3), .USB3_SLOE_N(oe3), .USB3_SLRD_N(rd3), .USB3_A(a3),
    .usb_rd_state(state3), .data_out(out3), .data_valid(valid3), .data_last(last3),
    .short_pkt(short3), .pkt_count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FX3 model: a strobe seen at an edge enters a LAT-1 deep delay line whose
  // tail drives DQ; idle slots carry random junk to expose misaligned capture.
  typedef struct {
    int          cyc;
    logic [31:0] word;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fx3_line [LAT];
  logic [31:0] fx3_base = 32'd0;
  int          fx3_issued = 0;
  bit          rd_prev = 1'b0;
  int          cyc = 0;
  logic [15:0] model_pkts = 16'd0;
  int          mon_valid = 0;
  int          mon_last  = 0;
  int          mon_short = 0;

  initial begin
    for (int i = 0; i < LAT; i++) fx3_line[i] = 32'd0;
  end

  always @(posedge clk) begin
    bit   rd_seen;
    exp_t e;
    rd_seen = (USB3_SLRD_N === 1'b0) && (rst_n === 1'b1);
    if (rd_prev && !rd_seen && exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = LAT - 1; i > 0; i--) fx3_line[i] = fx3_line[i-1];
    if (rd_seen) begin
      fx3_line[0] = fx3_base + fx3_issued;
      fx3_issued++;
      e.cyc  = cyc + LAT;
      e.word = fx3_line[0];
      e.last = 1'b0;
      exp_q.push_back(e);
    end else begin
      fx3_line[0] = $urandom;
    end
    rd_prev = rd_seen;
    cyc++;
    #1 USB3_DQ = fx3_line[LAT-2];
  end

  // Per-cycle monitor: scoreboard words and strobe/state relationships.
  always @(negedge clk) begin
    bit         exp_v;
    logic [2:0] strb_exp;
    if (rst_n === 1'b1) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (data_valid || exp_v) begin
        check("data_valid", data_valid, exp_v);
        if (exp_v) begin
          if (data_valid) begin
            check("data_out", data_out, exp_q[0].word);
            check("data_last", data_last, exp_q[0].last);
          end
          void'(exp_q.pop_front());
        end
      end
      if (data_valid) begin
        mon_valid++;
        if (data_last) mon_last++;
        check("valid_in_read_drain", (usb_rd_state == 4'd6) || (usb_rd_state == 4'd7), 1);
      end
      if (short_pkt) begin
        mon_short++;
        check("short_at_done", usb_rd_state, 4'd8);
      end
      case (usb_rd_state)
        4'd1:    strb_exp = 3'b011;
        4'd2:    strb_exp = 3'b001;
        4'd6:    strb_exp = 3'b000;
        4'd7:    strb_exp = 3'b001;
        default: strb_exp = 3'b111;
      endcase
      check("strobes", {USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N}, strb_exp);
      check("state_legal", usb_rd_state inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8}, 1);
      if (usb_rd_state == 4'd1) check("usb3_a", USB3_A, FA);
    end
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_state"}, usb_rd_state, 4'd0);
    check({pfx, "_slcs"}, USB3_SLCS_N, 1);
    check({pfx, "_sloe"}, USB3_SLOE_N, 1);
    check({pfx, "_slrd"}, USB3_SLRD_N, 1);
    check({pfx, "_addr"}, USB3_A, FA);
    check({pfx, "_data"}, data_out, 32'd0);
    check({pfx, "_valid"}, data_valid, 0);
    check({pfx, "_last"}, data_last, 0);
    check({pfx, "_short"}, short_pkt, 0);
    check({pfx, "_pkts"}, pkt_count, 16'd0);
  endtask

  // One packet: drop_at > 0 lowers FLAGA right after that many strobes.
  task automatic do_packet(input int drop_at, input bit wiggle, input logic [31:0] base);
    int         t, seen, exp_words, done_hold, k;
    logic [3:0] seq[$];
    int         rc[$];
    int         rl[$];
    int         exp_code[5];
    int         exp_len[4];
    fx3_base   = base;
    fx3_issued = 0;
    mon_valid  = 0;
    mon_last   = 0;
    mon_short  = 0;
    exp_words  = (drop_at > 0 && drop_at < BL) ? drop_at : BL;
    done_hold  = $urandom_range(0, 3);
    @(negedge clk);
    USB3_FLAGA = 1'b1;
    ds_ready   = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (usb_rd_state == 4'd0 && t < 100);
    check("addr_delay", t, 1);
    seen = 0;
    t = 0;
    while (usb_rd_state != 4'd0 && t < 4000) begin
      seq.push_back(usb_rd_state);
      if (USB3_SLRD_N == 1'b0) seen++;
      if (drop_at > 0 && seen == drop_at) USB3_FLAGA = 1'b0;
      if (usb_rd_state == 4'd8) begin
        if (done_hold == 0) USB3_FLAGA = 1'b0;
        else done_hold--;
      end
      if (wiggle) ds_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    check("pkt_finished", t < 4000, 1);
    ds_ready = 1'b1;
    check("words", mon_valid, exp_words);
    check("last_count", mon_last, 1);
    check("short_pulses", mon_short, (exp_words < BL) ? 1 : 0);
    if (exp_words == BL) model_pkts = model_pkts + 16'd1;
    check("pkt_count", pkt_count, model_pkts);
    foreach (seq[i]) begin
      if (rc.size() > 0 && rc[rc.size()-1] == int'(seq[i])) begin
        k = rl.pop_back();
        rl.push_back(k + 1);
      end else begin
        rc.push_back(int'(seq[i]));
        rl.push_back(1);
      end
    end
    exp_code = '{1, 2, 6, 7, 8};
    exp_len  = '{1, 1, exp_words, LAT};
    check("seq_runs", rc.size(), 5);
    for (int i = 0; i < 5 && i < rc.size(); i++) check("seq_code", rc[i], exp_code[i]);
    for (int i = 0; i < 4 && i < rl.size(); i++) check("seq_len", rl[i], exp_len[i]);
  endtask

  task automatic latency_test();
    int a, b, drain, nv;
    a = -1;
    b = -1;
    drain = 0;
    nv = 0;
    @(negedge clk);
    f3 = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rd3 == 1'b0 && a < 0) a = t;
      if (valid3) begin
        nv++;
        if (b < 0) b = t;
      end
      if (state3 == 4'd7) drain++;
      if (state3 == 4'd8) f3 = 1'b0;
      if (state3 == 4'd0 && a >= 0) break;
    end
    check("lat3_first_valid", b - a, 3);
    check("lat3_drain_len", drain, 3);
    check("lat3_words", nv, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, t, bad;
    rst_n      = 1'b0;
    USB3_FLAGA = 1'b1;
    ds_ready   = 1'b1;
    USB3_DQ    = 32'd0;
    f3         = 1'b0;
    ds3        = 1'b1;
    dq3        = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    USB3_FLAGA = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Full burst with DQ counting from zero.
    do_packet(0, 1'b0, 32'd0);
    // Early flag drop after 100 strobes.
    do_packet(100, 1'b0, 32'h1000_0000);

    // Backpressure: flag up, downstream not ready.
    @(negedge clk);
    USB3_FLAGA = 1'b1;
    ds_ready   = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (usb_rd_state != 4'd0 || !USB3_SLCS_N || !USB3_SLOE_N || !USB3_SLRD_N) bad++;
    end
    check("bp_hold_idle", bad, 0);
    do_packet(0, 1'b0, 32'h2000_0000);

    // Random packets: random drop points, ds_ready jitter, idle gaps.
    for (int p = 0; p < 6; p++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_packet(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BL + 20)) : 0, 1'b1,
                $urandom);
    end

    // Reset in the middle of READ.
    fx3_base   = 32'h3000_0000;
    fx3_issued = 0;
    @(negedge clk);
    USB3_FLAGA = 1'b1;
    ds_ready   = 1'b1;
    seen = 0;
    t = 0;
    while (seen < 40 && t < 500) begin
      @(negedge clk);
      t++;
      if (USB3_SLRD_N == 1'b0) seen++;
    end
    check("reach_word40", seen, 40);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    rd_prev    = 1'b0;
    USB3_FLAGA = 1'b0;
    model_pkts = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_valid = 0;
    repeat (20) @(negedge clk);
    check("no_valid_after_rst", mon_valid, 0);
    do_packet(0, 1'b0, 32'h4000_0000);

    latency_test();

    // Counter wrap from a preloaded value.
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.pkt_count_q;
    @(negedge clk);
    check("preload", pkt_count, 16'hFFFE);
    model_pkts = 16'hFFFE;
    do_packet(0, 1'b0, 32'h5000_0000);
    check("wrap_ffff", pkt_count, 16'hFFFF);
    do_packet(0, 1'b0, 32'h6000_0000);
    check("wrap_zero", pkt_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
